// File: rtl/proc_seq_pkg.sv
// proc_seq_pkg: shared types and instruction-field constants for the proc sequencer.
package proc_seq_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned FIELD_W = 3;

    // Instruction field positions within a 16-bit program word
    localparam int unsigned OP_LSB = 6;
    localparam int unsigned OP_MSB = OP_LSB + FIELD_W - 1;
    localparam int unsigned RX_LSB = 3;
    localparam int unsigned RY_LSB = 0;

    // Opcodes understood by proc; only mvi changes sequencing
    localparam logic [FIELD_W-1:0] OP_MV  = 3'b000;
    localparam logic [FIELD_W-1:0] OP_MVI = 3'b001;
    localparam logic [FIELD_W-1:0] OP_ADD = 3'b010;
    localparam logic [FIELD_W-1:0] OP_SUB = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_OPERAND,
        S_WAIT,
        S_HALT
    } state_t;

    function automatic logic [FIELD_W-1:0] opcode_of(input logic [WORD_W-1:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

    // mvi is the only two-word instruction
    function automatic logic is_mvi(input logic [WORD_W-1:0] word);
        return opcode_of(word) == OP_MVI;
    endfunction

endpackage

// File: rtl/proc_seq_ram.sv
// proc_seq_ram: DEPTH x 16 program store, synchronous write, asynchronous read.
module proc_seq_ram
    import proc_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/proc_sequencer.sv
// proc_sequencer: replays a stored program into proc over DIN/Run, one
// instruction per Done, capturing Bus into result.
// Optional watchdog on Done: define PROC_SEQ_TIMEOUT_EN.
module proc_sequencer
    import proc_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned AW      = $clog2(DEPTH),
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              start,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [WORD_W-1:0] prog_data,
    input  logic [AW:0]       prog_len,
    input  logic              Done,
    input  logic [WORD_W-1:0] Bus,
    output logic [WORD_W-1:0] DIN,
    output logic              Run,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [AW:0]       pc,
    output logic [WORD_W-1:0] result
);

    localparam int unsigned PW = AW + 1;

    state_t            state;
    logic [PW-1:0]     len_q;
    logic              mvi_q;
    logic [PW-1:0]     pc_inc1;
    logic [PW-1:0]     pc_adv;
    logic [AW-1:0]     rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic              word_mvi;
    logic              mvi_fits;
    logic              ram_we;

`ifdef PROC_SEQ_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] wd_cnt;
    logic [CW-1:0] wd_inc;
    logic          wd_hit;

    assign wd_inc = wd_cnt + CW'(1);
    assign wd_hit = (wd_inc == CW'(TIMEOUT));
`else
    // TIMEOUT only matters in the watchdog build
    if (TIMEOUT == 0) begin : g_timeout_unused
    end
`endif

    // Loads are only accepted while no program is running
    assign ram_we = prog_we && (state == S_IDLE || state == S_HALT);

    proc_seq_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (Clock),
        .we      (ram_we),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // pc never exceeds DEPTH, so +1/+2 fit in AW+1 bits without wrapping
    assign pc_inc1  = pc + PW'(1);
    assign pc_adv   = pc + (mvi_q ? PW'(2) : PW'(1));
    assign word_mvi = is_mvi(rd_data);
    assign mvi_fits = (pc_inc1 < len_q);

    // Single read address: operand word during OPERAND and while waiting on an mvi
    always_comb begin
        rd_addr = AW'(pc);
        if (state == S_OPERAND || (state == S_WAIT && mvi_q)) begin
            rd_addr = AW'(pc_inc1);
        end
    end

    // Word presented to proc; zero outside an active instruction
    always_comb begin
        DIN = '0;
        if (state == S_ISSUE || state == S_OPERAND || state == S_WAIT) begin
            DIN = rd_data;
        end
    end

    // Run pulses in ISSUE unless the mvi would read past the program end
    assign Run  = (state == S_ISSUE) && !(word_mvi && !mvi_fits);
    assign busy = (state == S_ISSUE) || (state == S_OPERAND) || (state == S_WAIT);

    // Sequencer state machine and status registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= S_IDLE;
            pc     <= '0;
            len_q  <= '0;
            mvi_q  <= 1'b0;
            halted <= 1'b0;
            err    <= 1'b0;
            result <= '0;
`ifdef PROC_SEQ_TIMEOUT_EN
            wd_cnt <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        len_q  <= prog_len;
                        pc     <= '0;
                        err    <= 1'b0;
                        halted <= (prog_len == '0);
                        state  <= (prog_len == '0) ? S_HALT : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mvi_q <= word_mvi;
`ifdef PROC_SEQ_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    if (word_mvi) begin
                        if (mvi_fits) begin
                            state <= S_OPERAND;
                        end else begin
                            err   <= 1'b1;
                            state <= S_HALT;
                        end
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_OPERAND: begin
`ifdef PROC_SEQ_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (Done) begin
                        result <= Bus;
                        pc     <= pc_adv;
                        if (pc_adv >= len_q) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
`ifdef PROC_SEQ_TIMEOUT_EN
                    else if (wd_hit) begin
                        err   <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        wd_cnt <= wd_inc;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_sequencer.sv
// tb_proc_sequencer: directed checks of the proc sequencer with a simple proc
// model that answers each Run with Done two cycles later.
module tb_proc_sequencer;

    logic        Clock;
    logic        Reset;
    logic        start;
    logic        prog_we;
    logic [4:0]  prog_addr;
    logic [15:0] prog_data;
    logic [5:0]  prog_len;
    logic        Done;
    logic [15:0] Bus;
    logic [15:0] DIN;
    logic        Run;
    logic        busy;
    logic        halted;
    logic        err;
    logic [5:0]  pc;
    logic [15:0] result;

    int          n_vec;
    int          n_err;
    int          n_done;
    logic [15:0] last_bus;
    logic [15:0] img [32];
    logic [1:0]  run_hist;
    logic        auto_done;
    logic        done_req;

    proc_sequencer #(
        .DEPTH   (32),
        .TIMEOUT (8)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .start     (start),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_len  (prog_len),
        .Done      (Done),
        .Bus       (Bus),
        .DIN       (DIN),
        .Run       (Run),
        .busy      (busy),
        .halted    (halted),
        .err       (err),
        .pc        (pc),
        .result    (result)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; strobes drop after the edge and the proc model updates Done/Bus
    task automatic tick();
        run_hist = {run_hist[0], Run};
        @(posedge Clock);
        #1;
        start    = 1'b0;
        prog_we  = 1'b0;
        Done     = (auto_done && run_hist[1]) || done_req;
        done_req = 1'b0;
        if (Done) begin
            Bus      = 16'hB000 + 16'(n_done);
            last_bus = Bus;
            n_done++;
        end else begin
            Bus = 16'hDEAD;
        end
    endtask

    task automatic write_word(input int addr, input logic [15:0] data);
        prog_we   = 1'b1;
        prog_addr = 5'(addr);
        prog_data = data;
        img[addr] = data;
        tick();
    endtask

    // Start a program and follow it word by word against the bench image
    task automatic run_prog(input logic [5:0] len, input bit poke, input string tag);
        int exp_pc;
        bit poked;
        exp_pc    = 0;
        poked     = 1'b0;
        auto_done = 1'b1;
        run_hist  = '0;
        prog_len  = len;
        start     = 1'b1;
        tick();
        for (int cyc = 0; cyc < 400 && busy; cyc++) begin
            if (Run) begin
                check_eq({tag, "_pc"}, 32'(pc), 32'(exp_pc));
                check_eq({tag, "_din"}, 32'(DIN), 32'(img[exp_pc]));
                if (poke && !poked) begin
                    start     = 1'b1;
                    prog_we   = 1'b1;
                    prog_addr = 5'd1;
                    prog_data = 16'hFFFF;
                    prog_len  = 6'd0;
                    poked     = 1'b1;
                end
                if (img[exp_pc][8:6] == 3'b001) begin
                    tick();
                    check_eq({tag, "_opnd_din"}, 32'(DIN), 32'(img[exp_pc + 1]));
                    check_eq({tag, "_opnd_run"}, 32'(Run), 0);
                    exp_pc += 2;
                end else begin
                    exp_pc += 1;
                end
            end
            tick();
        end
        check_eq({tag, "_end_busy"}, 32'(busy), 0);
        check_eq({tag, "_end_halted"}, 32'(halted), 1);
        check_eq({tag, "_end_err"}, 32'(err), 0);
        check_eq({tag, "_end_pc"}, 32'(pc), 32'(len));
        check_eq({tag, "_end_result"}, 32'(result), 32'(last_bus));
        check_eq({tag, "_end_din"}, 32'(DIN), 0);
        auto_done = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        n_done    = 0;
        last_bus  = '0;
        run_hist  = '0;
        auto_done = 1'b0;
        done_req  = 1'b0;
        Reset     = 1'b1;
        start     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        prog_len  = '0;
        Done      = 1'b0;
        Bus       = 16'hDEAD;

        // Reset values
        tick();
        tick();
        check_eq("rst_din", 32'(DIN), 0);
        check_eq("rst_run", 32'(Run), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_halted", 32'(halted), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_pc", 32'(pc), 0);
        check_eq("rst_result", 32'(result), 0);
        Reset = 1'b0;
        tick();

        // mvi + add, word 0 written in the same cycle as start
        write_word(1, 16'h0005);
        write_word(2, 16'h0081);
        img[0]    = 16'h0040;
        prog_we   = 1'b1;
        prog_addr = 5'd0;
        prog_data = 16'h0040;
        run_prog(6'd3, 1'b0, "mvi_prog");

        // Truncated mvi: never issued, err without halted
        write_word(0, 16'h0040);
        prog_len = 6'd1;
        start    = 1'b1;
        tick();
        check_eq("trunc_run", 32'(Run), 0);
        check_eq("trunc_din", 32'(DIN), 32'h0040);
        tick();
        check_eq("trunc_err", 32'(err), 1);
        check_eq("trunc_halted", 32'(halted), 0);
        check_eq("trunc_busy", 32'(busy), 0);
        check_eq("trunc_run2", 32'(Run), 0);

        // Empty program halts immediately
        prog_len = 6'd0;
        start    = 1'b1;
        tick();
        check_eq("len0_halted", 32'(halted), 1);
        check_eq("len0_busy", 32'(busy), 0);
        check_eq("len0_err", 32'(err), 0);
        check_eq("len0_run", 32'(Run), 0);
        tick();
        check_eq("len0_run2", 32'(Run), 0);

        // Reset while waiting for Done, then replay from 0
        write_word(0, 16'h0081);
        write_word(1, 16'h00C2);
        write_word(2, 16'h0003);
        run_hist = '0;
        prog_len = 6'd3;
        start    = 1'b1;
        tick();
        check_eq("rstw_run", 32'(Run), 1);
        tick();
        check_eq("rstw_busy", 32'(busy), 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_eq("rstw_busy0", 32'(busy), 0);
        check_eq("rstw_run0", 32'(Run), 0);
        check_eq("rstw_din0", 32'(DIN), 0);
        check_eq("rstw_pc0", 32'(pc), 0);
        run_prog(6'd3, 1'b0, "replay");

        // start/prog_we while busy are ignored; RAM checked by a rerun
        run_prog(6'd3, 1'b1, "poke");
        run_prog(6'd3, 1'b0, "after_poke");

        // Full-depth program ends with pc == DEPTH
        for (int i = 0; i < 32; i++) begin
            write_word(i, 16'h0080 | 16'(i));
        end
        run_prog(6'd32, 1'b0, "full");

`ifdef PROC_SEQ_TIMEOUT_EN
        // Watchdog: Done withheld for 8 WAIT cycles
        write_word(0, 16'h0081);
        write_word(1, 16'h00C2);
        run_hist = '0;
        prog_len = 6'd2;
        start    = 1'b1;
        tick();
        check_eq("wd_run", 32'(Run), 1);
        tick();
        repeat (7) tick();
        check_eq("wd_err_early", 32'(err), 0);
        check_eq("wd_busy_early", 32'(busy), 1);
        tick();
        check_eq("wd_err", 32'(err), 1);
        check_eq("wd_halted", 32'(halted), 0);
        check_eq("wd_busy", 32'(busy), 0);
        check_eq("wd_pc", 32'(pc), 0);

        // Done on the 8th WAIT cycle wins over the watchdog
        prog_len = 6'd2;
        start    = 1'b1;
        tick();
        tick();
        repeat (6) tick();
        done_req = 1'b1;
        tick();
        tick();
        check_eq("wd_race_run", 32'(Run), 1);
        check_eq("wd_race_pc", 32'(pc), 1);
        check_eq("wd_race_err", 32'(err), 0);
        check_eq("wd_race_result", 32'(result), 32'(last_bus));
        auto_done = 1'b1;
        for (int cyc = 0; cyc < 40 && busy; cyc++) begin
            tick();
        end
        auto_done = 1'b0;
        check_eq("wd_race_halted", 32'(halted), 1);
        check_eq("wd_race_end_pc", 32'(pc), 2);
        check_eq("wd_race_end_err", 32'(err), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/proc_sequencer.md
# proc_sequencer

Drives the DIN/Run side of the `proc` datapath so the processor can run a stored program without manual switch entry. It holds a small program RAM, which is loaded while the block is idle. It presents instruction and operand words on DIN, pulses Run and waits for Done, then advances. On each Done it captures the processor Bus value. It sits between a host or loader and the `proc` instance, in place of the SW[15:0]/SW[17] inputs.

## Interface
- `DEPTH`, 32: program RAM words; power of two, minimum 4.
- `AW`, $clog2(DEPTH): program address width.
- `TIMEOUT`, 255: Done watchdog limit in cycles. Used only with `PROC_SEQ_TIMEOUT_EN`.

- `Clock`  in  1  single clock, rising edge.
- `Reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request to run the program from address 0.
- `prog_we`  in  1  program RAM write strobe. Honoured only in IDLE or HALT.
- `prog_addr`  in  AW  write address.
- `prog_data`  in  16  write data.
- `prog_len`  in  AW+1  program length in words (0..DEPTH). Sampled on accepted `start`.
- `Done`  in  1  processor instruction-complete.
- `Bus`  in  16  processor bus.
- `DIN`  out  16  word to processor.
- `Run`  out  1  instruction issue pulse.
- `busy`  out  1  high in ISSUE, OPERAND, WAIT.
- `halted`  out  1  program completed normally.
- `err`  out  1  sticky fault: truncated mvi, or watchdog timeout.
- `pc`  out  AW+1  address of the current instruction word.
- `result`  out  16  Bus value captured on the last Done.

## Operation
- Instruction format:
  - DIN[8:6] is the opcode and DIN[5:3]/DIN[2:0] are the register fields.
  - Opcode 3'b001 is mvi, which is a two-word instruction: the next RAM word is the immediate.
  - All other opcodes are one word.
- The FSM has five states: IDLE, ISSUE, OPERAND, WAIT, HALT.
- Transitions:
  - IDLE/HALT + `start`: latch `prog_len`, set pc=0, clear `halted`/`err`.
    - If len=0, go to HALT.
    - Otherwise go to ISSUE.
  - ISSUE: DIN=ram[pc], Run=1 for exactly this cycle.
    - If the word is mvi and pc+1 < len, go to OPERAND.
    - If the word is mvi and pc+1 ≥ len, set `err`, drive Run=0 (the instruction is not issued) and go to HALT.
    - Otherwise go to WAIT.
  - OPERAND: DIN=ram[pc+1], Run=0. Go to WAIT, holding DIN.
  - WAIT: DIN stays at its last value and Run=0.
    - On Done: result←Bus; pc←pc+1, or pc+2 for mvi.
    - If the new pc ≥ len, set `halted` and go to HALT; otherwise go to ISSUE.
  - HALT: DIN=0. Waits for `start`.
- `start` is ignored while busy. `prog_we` is ignored while busy.
- Done seen outside WAIT is ignored.
- If `start` and `prog_we` occur in the same cycle in IDLE, both take effect. The first ISSUE reads the RAM one cycle later, so it sees the new word.
- Address arithmetic is AW+1 bits and never wraps. With len=DEPTH, pc=DEPTH is the terminal value.

## Timing
- Reset values: DIN=0, Run=0, busy=0, halted=0, err=0, pc=0, result=0, state IDLE. RAM contents are not cleared.
- Reset mid-program aborts within one cycle and returns to IDLE. Run is never asserted in the cycle after Reset.
- The RAM read is combinational from registered pc, so DIN is valid in the same cycle as Run.
- Latency from `start` to the first Run is 1 cycle.
- Latency from Done to the next Run is 1 cycle.
- DIN equals the operand exactly in the cycle after Run, which matches proc T1 sampling.
- `result` updates in the cycle after Done is sampled.

## Configuration
- `PROC_SEQ_TIMEOUT_EN` defined:
  - An 8+ bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches `TIMEOUT` with no Done: set `err` and go to HALT, with `halted`=0.
  - If Done arrives on the same cycle as the limit, Done wins.
- Not defined: no counter. WAIT waits indefinitely and the `TIMEOUT` parameter is unused.

## Structure
- `proc_seq_pkg` holds:
  - the state enum;
  - opcode constants: OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011;
  - the opcode field position constants.
- One sub-module, `proc_seq_ram`: DEPTH×16, one synchronous write port, one asynchronous read port. The FSM reads ram[pc] and ram[pc+1] through a single muxed address.

## Test plan
- Load ram={0x0040,0x0005,0x0081}, len=3, proc model Done 2 cycles after Run, then start.
  - Required: Run at the ISSUE of pc=0, DIN=0x0005 in the next cycle.
  - Required: the second Run has DIN=0x0081, pc sequence 0→2→3, halted=1, result=last Bus.
- ram[0]=0x0040, len=1, start.
  - Required: no Run asserted, err=1, halted=0, state HALT.
- len=0, start.
  - Required: HALT the next cycle, halted=1, Run never asserted.
- Assert Reset during WAIT of a 3-word program.
  - Required: next cycle busy=0, Run=0, DIN=0, pc=0. A reissued start replays from 0 with RAM intact.
- `start` and `prog_we` during busy.
  - Required: no restart and no RAM change (read back after HALT).
- With `PROC_SEQ_TIMEOUT_EN` and TIMEOUT=8, Done withheld.
  - Required: err=1 exactly 8 WAIT cycles after entry.
  - Required: Done on the 8th cycle instead gives err=0 and normal advance.
